// File: rtl/gen1_busarb.sv
// Two-master round-robin arbiter for the gen1 external memory bus.
// Optional transaction timeout is built when GEN1_ARB_TIMEOUT_EN is defined.
module gen1_busarb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_dout,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic        m0_exec,
  output logic [31:0] m0_din,
  output logic        m0_ready,
  output logic        m0_busx,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dout,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic        m1_exec,
  output logic [31:0] m1_din,
  output logic        m1_ready,
  output logic        m1_busx,
  output logic [31:0] xaddr,
  output logic [31:0] xdout,
  input  logic [31:0] xdin,
  output logic        memread,
  output logic        memwrite,
  output logic        memexec,
  input  logic        memready,
  input  logic        busx,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
`ifdef GEN1_ARB_TIMEOUT_EN
    , ERR = 2'd3
`endif
  } st_t;

  st_t  st_q, st_d;
  logic last_q, last_d;
  logic req0, req1, req_own;

`ifdef GEN1_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // Outside IDLE, last_q always names the master holding the grant.
  assign req_own = last_q ? req1 : req0;

  always_comb begin
    st_d   = st_q;
    last_d = last_q;
`ifdef GEN1_ARB_TIMEOUT_EN
    cnt_d  = cnt_q;
`endif
    case (st_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) begin
          st_d   = G0;
          last_d = 1'b0;
`ifdef GEN1_ARB_TIMEOUT_EN
          cnt_d  = '0;
`endif
        end else if (req1) begin
          st_d   = G1;
          last_d = 1'b1;
`ifdef GEN1_ARB_TIMEOUT_EN
          cnt_d  = '0;
`endif
        end
      end
      G0, G1: begin
        if (!req_own) st_d = IDLE;
`ifdef GEN1_ARB_TIMEOUT_EN
        else if (!memready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT)) st_d = ERR;
        end
`endif
      end
`ifdef GEN1_ARB_TIMEOUT_EN
      ERR: begin
        if (!req_own) st_d = IDLE;
      end
`endif
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      last_q <= 1'b1;
`ifdef GEN1_ARB_TIMEOUT_EN
      cnt_q  <= '0;
`endif
    end else begin
      st_q   <= st_d;
      last_q <= last_d;
`ifdef GEN1_ARB_TIMEOUT_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  // Bus muxing is combinational from the registered state so strobes follow the grant edge.
  always_comb begin
    gnt      = 2'b00;
    xaddr    = 32'h0;
    xdout    = 32'h0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memexec  = 1'b0;
    m0_din   = 32'h0;
    m0_ready = 1'b0;
    m0_busx  = 1'b0;
    m1_din   = 32'h0;
    m1_ready = 1'b0;
    m1_busx  = 1'b0;
    case (st_q)
      G0: begin
        gnt      = 2'b01;
        xaddr    = m0_addr;
        xdout    = m0_dout;
        memread  = m0_read;
        memwrite = m0_write;
        memexec  = m0_exec;
        m0_din   = xdin;
        m0_ready = memready;
        m0_busx  = busx & memready;
      end
      G1: begin
        gnt      = 2'b10;
        xaddr    = m1_addr;
        xdout    = m1_dout;
        memread  = m1_read;
        memwrite = m1_write;
        memexec  = m1_exec;
        m1_din   = xdin;
        m1_ready = memready;
        m1_busx  = busx & memready;
      end
`ifdef GEN1_ARB_TIMEOUT_EN
      ERR: begin
        if (last_q) begin
          gnt      = 2'b10;
          m1_ready = 1'b1;
          m1_busx  = 1'b1;
        end else begin
          gnt      = 2'b01;
          m0_ready = 1'b1;
          m0_busx  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gen1_busarb.sv
// Bench for gen1_busarb: directed scenarios followed by random two-master traffic
// compared against a transaction-level model of the arbitration rules.
module tb_gen1_busarb;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m_addr [2];
  logic [31:0] m_dout [2];
  logic        m_read [2];
  logic        m_write[2];
  logic        m_exec [2];
  logic [31:0] m0_din, m1_din, xaddr, xdout, xdin;
  logic        m0_ready, m0_busx, m1_ready, m1_busx;
  logic        memread, memwrite, memexec, memready, busx;
  logic [1:0]  gnt;

  always #5 clk = ~clk;

  gen1_busarb #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m_addr[0]), .m0_dout(m_dout[0]), .m0_read(m_read[0]),
    .m0_write(m_write[0]), .m0_exec(m_exec[0]),
    .m0_din(m0_din), .m0_ready(m0_ready), .m0_busx(m0_busx),
    .m1_addr(m_addr[1]), .m1_dout(m_dout[1]), .m1_read(m_read[1]),
    .m1_write(m_write[1]), .m1_exec(m_exec[1]),
    .m1_din(m1_din), .m1_ready(m1_ready), .m1_busx(m1_busx),
    .xaddr(xaddr), .xdout(xdout), .xdin(xdin),
    .memread(memread), .memwrite(memwrite), .memexec(memexec),
    .memready(memready), .busx(busx), .gnt(gnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus (-1 none), who was granted last, stall timer.
  int   owner;
  int   last;
  int   timer;
  bit   err;
  bit   req_edge[2];
  logic [1:0] prev_gnt;
  int   dut_last;
  logic exp_rdy[2];
  bit   active[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit req(input int i);
    return bit'(m_read[i] | m_write[i]);
  endfunction

  task automatic model_reset();
    owner = -1; last = 1; timer = 0; err = 0;
    prev_gnt = 2'b00; dut_last = 1;
    exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0;
  endtask

  task automatic model_update();
    req_edge[0] = req(0);
    req_edge[1] = req(1);
    if (owner < 0) begin
      if (req_edge[0] && (!req_edge[1] || last == 1)) owner = 0;
      else if (req_edge[1]) owner = 1;
      if (owner >= 0) begin last = owner; timer = 0; end
    end else if (err) begin
      if (!req_edge[owner]) begin owner = -1; err = 0; end
    end else if (!req_edge[owner]) begin
      owner = -1;
    end else begin
`ifdef GEN1_ARB_TIMEOUT_EN
      if (!memready) begin
        timer++;
        if (timer == TO) err = 1;
      end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_all();
    logic [1:0]  eg;
    logic [31:0] ea, ed;
    logic        er, ew, ee;
    logic [31:0] edin[2];
    logic        ebx[2];
    bit          skip_bus;
    int          w;
    #1;
    eg = 2'b00; ea = 32'h0; ed = 32'h0; er = 1'b0; ew = 1'b0; ee = 1'b0;
    edin[0] = 32'h0; edin[1] = 32'h0; ebx[0] = 1'b0; ebx[1] = 1'b0;
    exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0;
    skip_bus = 0;
    if (owner >= 0) begin
      eg = (owner == 1) ? 2'b10 : 2'b01;
      if (err) begin
        exp_rdy[owner] = 1'b1;
        ebx[owner] = 1'b1;
        skip_bus = 1;
      end else begin
        ea = m_addr[owner]; ed = m_dout[owner];
        er = m_read[owner]; ew = m_write[owner]; ee = m_exec[owner];
        edin[owner] = xdin;
        exp_rdy[owner] = memready;
        ebx[owner] = busx & memready;
      end
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("memread", 32'(memread), 32'(er));
    chk("memwrite", 32'(memwrite), 32'(ew));
    chk("memexec", 32'(memexec), 32'(ee));
    if (!skip_bus) begin
      chk("xaddr", xaddr, ea);
      chk("xdout", xdout, ed);
    end
    chk("m0_ready", 32'(m0_ready), 32'(exp_rdy[0]));
    chk("m1_ready", 32'(m1_ready), 32'(exp_rdy[1]));
    chk("m0_busx", 32'(m0_busx), 32'(ebx[0]));
    chk("m1_busx", 32'(m1_busx), 32'(ebx[1]));
    if (!(skip_bus && owner == 0)) chk("m0_din", m0_din, edin[0]);
    if (!(skip_bus && owner == 1)) chk("m1_din", m1_din, edin[1]);
    // Fairness: a contested grant must never repeat the previous winner.
    if (prev_gnt == 2'b00 && gnt != 2'b00) begin
      w = gnt[1] ? 1 : 0;
      if (req_edge[1 - w]) chk("alternation", 32'(w == dut_last), 32'd0);
      dut_last = w;
    end
    prev_gnt = gnt;
  endtask

  task automatic drive_random();
    bit mem_act;
    for (int i = 0; i < 2; i++) begin
      if (active[i]) begin
        if (exp_rdy[i] || $urandom_range(0, 49) == 0) begin
          active[i] = 0;
          m_read[i] = 1'b0; m_write[i] = 1'b0; m_exec[i] = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        active[i]  = 1;
        m_addr[i]  = $urandom;
        m_dout[i]  = $urandom;
        m_read[i]  = 1'($urandom_range(0, 1));
        m_write[i] = ~m_read[i];
        m_exec[i]  = m_read[i] & 1'($urandom_range(0, 1));
      end
    end
    mem_act  = (owner >= 0) && !err && req(owner);
    memready = mem_act && ($urandom_range(0, 2) == 0);
    busx     = memready && ($urandom_range(0, 7) == 0);
    xdin     = $urandom;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 32'h0; m_dout[i] = 32'h0;
      m_read[i] = 1'b0; m_write[i] = 1'b0; m_exec[i] = 1'b0;
      active[i] = 0; req_edge[i] = 0;
    end
    memready = 1'b0; busx = 1'b0; xdin = 32'h1234_5678;
    model_reset();
    #1 reset = 1'b1;
    check_all();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Single master read with delayed completion
    m_read[0] = 1'b1; m_exec[0] = 1'b1; m_addr[0] = 32'h100; m_addr[1] = 32'h555;
    check_all();
    tick(); check_all();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_xaddr", xaddr, 32'h100);
    chk("t1_memexec", 32'(memexec), 32'h1);
    tick(); check_all();
    tick();
    memready = 1'b1; xdin = 32'hDEADBEEF;
    check_all();
    chk("t1_m0_din", m0_din, 32'hDEADBEEF);
    chk("t1_m0_ready", 32'(m0_ready), 32'h1);
    chk("t1_m1_ready", 32'(m1_ready), 32'h0);
    chk("t1_m1_din", m1_din, 32'h0);
    tick();
    m_read[0] = 1'b0; m_exec[0] = 1'b0; memready = 1'b0;
    check_all();
    tick(); check_all();
    chk("t1_idle", 32'(gnt), 32'h0);

    // Contention straight after reset, then exception on m1
    reset = 1'b1; #2 reset = 1'b0; model_reset();
    m_write[0] = 1'b1; m_addr[0] = 32'h200; m_dout[0] = 32'hA0A0_0001;
    m_write[1] = 1'b1; m_addr[1] = 32'h300; m_dout[1] = 32'hB1B1_0002;
    check_all();
    tick(); check_all();
    chk("t2_first_m0", 32'(gnt), 32'h1);
    chk("t2_xdout0", xdout, 32'hA0A0_0001);
    memready = 1'b1; check_all();
    tick();
    m_write[0] = 1'b0; memready = 1'b0; check_all();
    tick(); check_all();
    chk("t2_gap_gnt", 32'(gnt), 32'h0);
    chk("t2_gap_wr", 32'(memwrite), 32'h0);
    m_write[0] = 1'b1; m_dout[0] = 32'hA0A0_0003;
    check_all();
    tick(); check_all();
    chk("t2_m1_next", 32'(gnt), 32'h2);
    chk("t2_xdout1", xdout, 32'hB1B1_0002);
    memready = 1'b1; busx = 1'b1; check_all();
    chk("t3_m1_busx", 32'(m1_busx), 32'h1);
    chk("t3_m0_busx", 32'(m0_busx), 32'h0);
    tick();
    m_write[1] = 1'b0; memready = 1'b0; busx = 1'b0; check_all();
    tick(); check_all();
    tick(); check_all();
    chk("t2_m0_third", 32'(gnt), 32'h1);
    chk("t2_xdout0b", xdout, 32'hA0A0_0003);
    m_write[1] = 1'b1; m_dout[1] = 32'hB1B1_0004;
    memready = 1'b1; check_all();
    tick();
    m_write[0] = 1'b0; memready = 1'b0; check_all();
    tick(); check_all();
    m_write[0] = 1'b1;
    tick(); check_all();
    chk("t4_g1", 32'(gnt), 32'h2);
    chk("t4_memwrite", 32'(memwrite), 32'h1);

    // Asynchronous reset in the middle of the m1 transaction
    memready = 1'b1;
    #2;
    chk("t4_pre_rdy", 32'(m1_ready), 32'h1);
    reset = 1'b1;
    #1;
    chk("t4_rst_memwrite", 32'(memwrite), 32'h0);
    chk("t4_rst_gnt", 32'(gnt), 32'h0);
    chk("t4_rst_m1_ready", 32'(m1_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0; memready = 1'b0; model_reset();
    check_all();
    tick(); check_all();
    chk("t4_after_rst_m0", 32'(gnt), 32'h1);
    m_write[0] = 1'b0; m_write[1] = 1'b0; check_all();
    tick(); check_all();

    // Stalled memory
    m_read[0] = 1'b1; m_addr[0] = 32'h400;
    check_all();
    tick(); check_all();
    chk("t5_gnt", 32'(gnt), 32'h1);
`ifdef GEN1_ARB_TIMEOUT_EN
    repeat (3) begin
      tick(); check_all();
      chk("t5_wait_rd", 32'(memread), 32'h1);
    end
    tick(); check_all();
    chk("t5_to_rd", 32'(memread), 32'h0);
    chk("t5_to_rdy", 32'(m0_ready), 32'h1);
    chk("t5_to_busx", 32'(m0_busx), 32'h1);
    chk("t5_to_gnt", 32'(gnt), 32'h1);
`else
    repeat (100) begin
      tick(); check_all();
      chk("t5_hold_gnt", 32'(gnt), 32'h1);
      chk("t5_hold_rd", 32'(memread), 32'h1);
    end
`endif
    m_read[0] = 1'b0; check_all();
    tick(); check_all();
    chk("t5_release", 32'(gnt), 32'h0);

    // Random two-master traffic
    active[0] = 0; active[1] = 0;
    repeat (3000) begin
      tick();
      drive_random();
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
